// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame monitor.
package uart_pkg;

  // Parity mode selector; values match the PARITY parameter encoding.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Widest supported data field.
  localparam int MAX_DATA_BITS = 9;

  // FIFO entry layout, MSB first: {break, frame_err, parity_err, data}.
  // Instances carry only DATA_BITS of data; entry_width() gives the packed width.
  typedef struct packed {
    logic                     brk;
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Packed width of one FIFO entry for a given data width.
  function automatic int entry_width(input int data_bits);
    return data_bits + 3;
  endfunction

endpackage

// File: rtl/uart_frame_monitor_sync_fifo.sv
// First-word-fall-through FIFO; a push while full is dropped unless a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push while full still fits.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  // Storage write; contents need no reset because occupancy gates the read side.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Head presented combinationally; zero while empty so outputs are clean after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/uart_frame_monitor.sv
// Oversampled UART receiver with parity/framing/break detection feeding a FWFT frame FIFO.
module uart_frame_monitor
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic                          out_valid,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_parity_err,
  output logic                          out_frame_err,
  output logic                          out_break,
  input  logic                          out_pop,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TICK_DIV = (CLK_FREQ_MHZ * 1000000 + BAUD_RATE * OVERSAMPLE / 2)
                            / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT_CLKS = TICK_DIV * OVERSAMPLE;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int HW = $clog2(BIT_CLKS + 1);
  localparam int EW = entry_width(DATA_BITS);
  localparam parity_e         PAR_MODE  = parity_e'(PARITY);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0]   OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0]   OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(BIT_CLKS - 1);

  logic sync1_reg, sync2_reg, prev_reg;
  logic rx_line, fall;

  rx_state_e      state_reg, state_next;
  logic [TW-1:0]  tick_reg, tick_next;
  logic [OW-1:0]  os_reg, os_next;
  logic [3:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic           perr_reg, perr_next;
  logic           ferr_reg, ferr_next;
  logic           par_low_reg, par_low_next;
  logic           stop_cnt_reg, stop_cnt_next;
  logic           stop1_low_reg, stop1_low_next;
  logic           hold_reg, hold_next;
  logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;

  logic           tick, sample, par_exp, first_stop_low;
  logic           push, push_brk, push_ferr;
  logic [EW-1:0]  push_vec, head_vec;
  logic           fifo_full, fifo_empty, fifo_drop;
  logic           overflow_reg;

  // Two-flop synchroniser plus one stage of history for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rx_line = sync2_reg;
  assign fall    = prev_reg & ~rx_line;

  // FSM and datapath state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      tick_reg      <= '0;
      os_reg        <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      perr_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
      par_low_reg   <= 1'b1;
      stop_cnt_reg  <= 1'b0;
      stop1_low_reg <= 1'b0;
      hold_reg      <= 1'b0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      os_reg        <= os_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      perr_reg      <= perr_next;
      ferr_reg      <= ferr_next;
      par_low_reg   <= par_low_next;
      stop_cnt_reg  <= stop_cnt_next;
      stop1_low_reg <= stop1_low_next;
      hold_reg      <= hold_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  // Next-state logic: divider, mid-bit sampling, error accumulation and push decision.
  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    os_next        = os_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    perr_next      = perr_reg;
    ferr_next      = ferr_reg;
    par_low_next   = par_low_reg;
    stop_cnt_next  = stop_cnt_reg;
    stop1_low_next = stop1_low_reg;
    hold_next      = hold_reg;
    hold_cnt_next  = hold_cnt_reg;
    push           = 1'b0;
    push_brk       = 1'b0;
    push_ferr      = 1'b0;
    first_stop_low = 1'b0;
    tick           = (tick_reg == TICK_LAST);
    sample         = tick && (os_reg == OS_MID);
    par_exp        = (PAR_MODE == PAR_EVEN) ? ^shift_reg : ~^shift_reg;

    if (state_reg != ST_IDLE) begin
      tick_next = tick ? '0 : tick_reg + 1'b1;
      if (tick) os_next = (os_reg == OS_LAST) ? '0 : os_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        tick_next = '0;
        os_next   = '0;
        if (hold_reg) begin
          // After a break, wait for a full bit time of continuous high line.
          if (!rx_line) begin
            hold_cnt_next = '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            hold_next     = 1'b0;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end else if (fall) begin
          state_next     = ST_START;
          bit_next       = '0;
          perr_next      = 1'b0;
          ferr_next      = 1'b0;
          par_low_next   = 1'b1;
          stop_cnt_next  = 1'b0;
          stop1_low_next = 1'b0;
        end
      end
      ST_START: begin
        if (sample) state_next = rx_line ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          shift_next = {rx_line, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == DATA_LAST) begin
            state_next = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          perr_next    = (rx_line != par_exp);
          par_low_next = ~rx_line;
          state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (stop_cnt_reg == 1'b0) stop1_low_next = ~rx_line;
          if (!rx_line) ferr_next = 1'b1;
          if (stop_cnt_reg == STOP_LAST) begin
            first_stop_low = (stop_cnt_reg == 1'b0) ? ~rx_line : stop1_low_reg;
            push_brk       = (shift_reg == '0) && par_low_reg && first_stop_low;
            push_ferr      = ferr_reg | ~rx_line | push_brk;
            push           = 1'b1;
            state_next     = ST_IDLE;
            hold_next      = push_brk;
            hold_cnt_next  = '0;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push_vec = {push_brk, push_ferr, perr_reg, shift_reg};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_vec),
    .pop       (out_pop),
    .pop_data  (head_vec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (fifo_drop && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow  = overflow_reg;
  assign out_valid = ~fifo_empty;
  assign {out_break, out_frame_err, out_parity_err, out_data} = head_vec;

endmodule

// File: tb/tb_uart_frame_monitor.sv
// Scoreboard bench for uart_frame_monitor: default 8N1 instance plus an even-parity instance.
module tb_uart_frame_monitor;
  localparam int BIT_CLKS = 240;
  localparam int LAT_NOM  = 2284;
  localparam int WAIT_MAX = 3000;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rx, rx_p, out_pop, p_pop, overflow_clr, p_clr;
  logic       out_valid, out_parity_err, out_frame_err, out_break, overflow;
  logic [7:0] out_data;
  logic [4:0] fifo_count;
  logic       p_valid, p_parity_err, p_frame_err, p_break, p_overflow;
  logic [7:0] p_data;
  logic [4:0] p_count;

  exp_t exp_q[$];
  exp_t exp_pq[$];
  int   checks = 0;
  int   errors = 0;

  uart_frame_monitor dut (
    .clk(clk), .reset(reset), .uart_rx(rx),
    .out_valid(out_valid), .out_data(out_data), .out_parity_err(out_parity_err),
    .out_frame_err(out_frame_err), .out_break(out_break), .out_pop(out_pop),
    .overflow(overflow), .overflow_clr(overflow_clr), .fifo_count(fifo_count)
  );

  uart_frame_monitor #(.PARITY(2)) dut_p (
    .clk(clk), .reset(reset), .uart_rx(rx_p),
    .out_valid(p_valid), .out_data(p_data), .out_parity_err(p_parity_err),
    .out_frame_err(p_frame_err), .out_break(p_break), .out_pop(p_pop),
    .overflow(p_overflow), .overflow_clr(p_clr), .fifo_count(p_count)
  );

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx = v;
    else rx_p = v;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_val);
    set_line(which, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_line(which, data[i]);
      hold_bits(1);
    end
    if (has_par) begin
      set_line(which, par_bit);
      hold_bits(1);
    end
    set_line(which, stop_val);
    hold_bits(1);
    set_line(which, 1'b1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr, input logic brk);
    exp_t e;
    e.data = d; e.perr = perr; e.ferr = ferr; e.brk = brk;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: valid=%b count=%0d ovf=%b want 0/0/0", out_valid, fifo_count, overflow);
    end
    checks++;
    if ({out_break, out_frame_err, out_parity_err, out_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_head: got %h want 000", {out_break, out_frame_err, out_parity_err, out_data});
    end
    checks++;
    if (p_valid !== 1'b0 || p_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_parity_dut: valid=%b count=%0d want 0/0", p_valid, p_count);
    end
    reset = 1'b0;
    hold_bits(1);
  endtask

  task automatic test_basic();
    int lat = 0;
    exp_t e;
    push_exp(8'h48, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(0, 8'h48, 1'b0, 1'b0, 1'b1);
      begin
        while (!out_valid && lat < WAIT_MAX) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d clocks want %0d +/-2", lat, LAT_NOM);
    end
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL basic_count: got %0d want 1", fifo_count);
    end
    while (exp_q.size() > 0) begin
      int n = 0;
      while (!out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      $display("txn basic data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
      if ({out_valid, out_break, out_frame_err, out_parity_err, out_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL basic_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", out_valid, out_break, out_frame_err,
                 out_parity_err, out_data, e.brk, e.ferr, e.perr, e.data);
      end
      out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL basic_drained: valid=%b count=%0d want 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d [2];
    logic       pb [2];
    exp_t e;
    d[0] = 8'hA5; pb[0] = 1'b1;       // even parity of A5 is 0, so 1 is wrong
    d[1] = 8'h07; pb[1] = ^d[1];      // correct even parity
    for (int i = 0; i < 2; i++) begin
      e.data = d[i]; e.perr = (pb[i] != ^d[i]); e.ferr = 1'b0; e.brk = 1'b0;
      exp_pq.push_back(e);
      send_frame(1, d[i], 1'b1, pb[i], 1'b1);
    end
    hold_bits(1);
    while (exp_pq.size() > 0) begin
      int n = 0;
      while (!p_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_pq.pop_front();
      checks++;
      $display("txn parity data=%h perr=%b ferr=%b brk=%b", p_data, p_parity_err, p_frame_err, p_break);
      if ({p_valid, p_break, p_frame_err, p_parity_err, p_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL parity_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", p_valid, p_break, p_frame_err,
                 p_parity_err, p_data, e.brk, e.ferr, e.perr, e.data);
      end
      p_pop = 1'b1; @(negedge clk); p_pop = 1'b0;
    end
  endtask

  task automatic test_frame_err();
    exp_t e;
    push_exp(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    hold_bits(1);
    push_exp(8'h0F, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    hold_bits(1);
    while (exp_q.size() > 0) begin
      int n = 0;
      while (!out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      $display("txn frame data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
      if ({out_valid, out_break, out_frame_err, out_parity_err, out_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL frame_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", out_valid, out_break, out_frame_err,
                 out_parity_err, out_data, e.brk, e.ferr, e.perr, e.data);
      end
      out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
    end
  endtask

  task automatic test_break();
    exp_t e;
    push_exp(8'h00, 1'b0, 1'b1, 1'b1);
    set_line(0, 1'b0);
    hold_bits(20);
    set_line(0, 1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    // Line has not yet idled a full bit, so this frame must be ignored.
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    hold_bits(2);
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL break_single_entry: count=%0d want 1", fifo_count);
    end
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    hold_bits(1);
    while (exp_q.size() > 0) begin
      int n = 0;
      while (!out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      $display("txn break data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
      if ({out_valid, out_break, out_frame_err, out_parity_err, out_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL break_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", out_valid, out_break, out_frame_err,
                 out_parity_err, out_data, e.brk, e.ferr, e.perr, e.data);
      end
      out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push_exp(8'(i), 1'b0, 1'b0, 1'b0);
      send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    hold_bits(1);
    checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: count=%0d ovf=%b want 16/1", fifo_count, overflow);
    end
    overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    exp_t e;
    fork
      send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
      begin
        // Land the pop on the same clock as the stop-bit push.
        repeat (LAT_NOM - 2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        $display("txn pushpop data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
        if ({out_valid, out_data} !== {1'b1, e.data}) begin
          errors++;
          $display("FAIL pushpop_head: got v=%b %h want 1 %h", out_valid, out_data, e.data);
        end
        out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
        checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL pushpop_count: count=%0d ovf=%b want 16/0", fifo_count, overflow);
        end
      end
    join
    push_exp(8'h77, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      int n = 0;
      while (!out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      $display("txn full data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
      if ({out_valid, out_break, out_frame_err, out_parity_err, out_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL full_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", out_valid, out_break, out_frame_err,
                 out_parity_err, out_data, e.brk, e.ferr, e.perr, e.data);
      end
      out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL full_drained: count=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_glitch();
    set_line(0, 1'b0);
    repeat (3) @(negedge clk);
    set_line(0, 1'b1);
    hold_bits(1);
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL glitch_no_entry: valid=%b count=%0d want 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    exp_t e;
    send_frame(0, 8'h21, 1'b0, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL resetmid_prefill: count=%0d want 1", fifo_count);
    end
    d = 8'h33;
    set_line(0, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 3; i++) begin
      set_line(0, d[i]);
      hold_bits(1);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_line(0, 1'b1);
    exp_q.delete();
    checks++;
    if (fifo_count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resetmid_flush: count=%0d valid=%b want 0/0", fifo_count, out_valid);
    end
    hold_bits(2);
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL resetmid_aborted: count=%0d want 0", fifo_count);
    end
    push_exp(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    hold_bits(1);
    while (exp_q.size() > 0) begin
      int n = 0;
      while (!out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      $display("txn resetmid data=%h perr=%b ferr=%b brk=%b", out_data, out_parity_err, out_frame_err, out_break);
      if ({out_valid, out_break, out_frame_err, out_parity_err, out_data} !== {1'b1, e.brk, e.ferr, e.perr, e.data}) begin
        errors++;
        $display("FAIL resetmid_entry: got v=%b %b%b%b %h want 1 %b%b%b %h", out_valid, out_break, out_frame_err,
                 out_parity_err, out_data, e.brk, e.ferr, e.perr, e.data);
      end
      out_pop = 1'b1; @(negedge clk); out_pop = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_p = 1'b1;
    out_pop = 1'b0;
    p_pop = 1'b0;
    overflow_clr = 1'b0;
    p_clr = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_break();
    test_overflow();
    test_push_pop_full();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
